// File: rtl/lovers_bec_loader_if.sv
// Control-bus bundle between the BEC controller (master) and the loader (slave).
// Carries the operand-load handshake, the key-bit fetch pair and the result return.
interface lovers_bec_loader_if #(
   parameter int unsigned M = 163
);
   logic         enable;
   logic         load_data;
   logic [2:0]   load_status;
   logic [M-1:0] data_in;
   logic         ki;
   logic         trigLoad;
   logic         next_key;
   logic [3:0]   becStatus;
   logic [M-1:0] data_out;
   logic         done;

   modport master (
      output enable, load_data, load_status, data_in, ki,
      input  trigLoad, next_key, becStatus, data_out, done
   );

   modport slave (
      input  enable, load_data, load_status, data_in, ki,
      output trigLoad, next_key, becStatus, data_out, done
   );
endinterface

// File: rtl/lovers_bec_loader.sv
// BEC core control-bus responder: loads operands, fetches key bits one at a time
// for the ladder datapath and returns the datapath result with done.
module lovers_bec_loader #(
   parameter int unsigned M        = 163,
   parameter int unsigned KEY_BITS = 163
) (
   input  logic                 clk,
   input  logic                 rst,
   lovers_bec_loader_if.slave   bus,
   output logic [M-1:0]         xp_o,
   output logic [M-1:0]         yp_o,
   output logic [M-1:0]         w_o,
   output logic [M-1:0]         d_o,
   output logic                 key_bit_o,
   output logic                 key_valid_o,
   input  logic                 step_ready_i,
   input  logic                 dp_done_i,
   input  logic [M-1:0]         result_i
);
   localparam logic [7:0] KeyBitsCnt = 8'(KEY_BITS);

   typedef enum logic [2:0] {StIdle, StReq, StWaitKi, StStep, StDrain, StFinish} state_e;

   state_e       state_q, state_d;
   logic [M-1:0] xp_q, xp_d, yp_q, yp_d, w_q, w_d, d_q, d_d;
   logic [M-1:0] dout_q, dout_d;
   logic [3:0]   loaded_q, loaded_d;
   logic [7:0]   cnt_q, cnt_d;
   logic         key_bit_q, key_bit_d;
   logic         trig_q, trig_d;
   logic [3:0]   err_q, err_d;     // sticky abort/invalid-load code, 0 when none
   logic [3:0]   status_q, status_d;

   always_comb begin
      state_d   = state_q;
      xp_d      = xp_q;
      yp_d      = yp_q;
      w_d       = w_q;
      d_d       = d_q;
      dout_d    = dout_q;
      loaded_d  = loaded_q;
      cnt_d     = cnt_q;
      key_bit_d = key_bit_q;
      err_d     = err_q;
      trig_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.load_data) begin
               trig_d = 1'b1;
               err_d  = 4'h0;
               case (bus.load_status)
                  3'd0:    begin xp_d = bus.data_in; loaded_d[0] = 1'b1; end
                  3'd1:    begin yp_d = bus.data_in; loaded_d[1] = 1'b1; end
                  3'd2:    begin w_d  = bus.data_in; loaded_d[2] = 1'b1; end
                  3'd3:    begin d_d  = bus.data_in; loaded_d[3] = 1'b1; end
                  default: err_d = 4'hF;
               endcase
            end
            if (bus.enable && loaded_q == 4'b1111) begin
               state_d = StReq;
               err_d   = 4'h0;
            end
         end
         StReq:    state_d = StWaitKi;
         StWaitKi: begin
            key_bit_d = bus.ki;
            state_d   = StStep;
         end
         StStep: begin
            if (step_ready_i) begin
               cnt_d   = cnt_q + 8'd1;
               state_d = (cnt_d == KeyBitsCnt) ? StDrain : StReq;
            end
         end
         StDrain: begin
            if (dp_done_i) begin
               dout_d  = result_i;
               state_d = StFinish;
            end
         end
         StFinish: begin
            if (!bus.enable) begin
               loaded_d = 4'b0000;
               cnt_d    = 8'd0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Abort beats any progress computed above for the same cycle.
      if (!bus.enable && state_q inside {StReq, StWaitKi, StStep, StDrain}) begin
         state_d   = StIdle;
         cnt_d     = 8'd0;
         err_d     = 4'hE;
         dout_d    = dout_q;
         key_bit_d = key_bit_q;
      end

      status_d = 4'h0;
      unique case (state_d)
         StIdle: begin
            if (err_d != 4'h0)             status_d = err_d;
            else if (loaded_d == 4'b0000)  status_d = 4'h0;
            else if (loaded_d == 4'b1111)  status_d = 4'h2;
            else                           status_d = 4'h1;
         end
         StReq, StWaitKi, StStep: status_d = 4'h3;
         StDrain:                 status_d = 4'h4;
         StFinish:                status_d = 4'h5;
         default:                 status_d = 4'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         xp_q      <= '0;
         yp_q      <= '0;
         w_q       <= '0;
         d_q       <= '0;
         dout_q    <= '0;
         loaded_q  <= 4'b0000;
         cnt_q     <= 8'd0;
         key_bit_q <= 1'b0;
         trig_q    <= 1'b0;
         err_q     <= 4'h0;
         status_q  <= 4'h0;
      end else begin
         state_q   <= state_d;
         xp_q      <= xp_d;
         yp_q      <= yp_d;
         w_q       <= w_d;
         d_q       <= d_d;
         dout_q    <= dout_d;
         loaded_q  <= loaded_d;
         cnt_q     <= cnt_d;
         key_bit_q <= key_bit_d;
         trig_q    <= trig_d;
         err_q     <= err_d;
         status_q  <= status_d;
      end
   end

   assign bus.trigLoad  = trig_q;
   assign bus.next_key  = (state_q == StReq);
   assign bus.becStatus = status_q;
   assign bus.data_out  = dout_q;
   assign bus.done      = (state_q == StFinish);
   assign xp_o          = xp_q;
   assign yp_o          = yp_q;
   assign w_o           = w_q;
   assign d_o           = d_q;
   assign key_bit_o     = key_bit_q;
   assign key_valid_o   = (state_q == StStep);
endmodule

// File: tb/tb_lovers_bec_loader.sv
// Self-checking bench for lovers_bec_loader: directed stimulus, a per-cycle
// behavioural model compare, and hand-computed literal checks.
module tb_lovers_bec_loader;
   localparam int unsigned M        = 163;
   localparam int unsigned KEY_BITS = 163;
   localparam int MIdle = 0, MFetch = 1, MDrain = 2, MFinish = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [M-1:0] xp_o, yp_o, w_o, d_o, result_i;
   logic         key_bit_o, key_valid_o, step_ready_i, dp_done_i;

   int tests = 0;
   int fails = 0;
   int nk = 0;
   int key_idx = 0;
   int exp_st [4] = '{1, 1, 1, 2};

   lovers_bec_loader_if #(.M(M)) bus ();

   lovers_bec_loader #(.M(M), .KEY_BITS(KEY_BITS)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .xp_o         (xp_o),
      .yp_o         (yp_o),
      .w_o          (w_o),
      .d_o          (d_o),
      .key_bit_o    (key_bit_o),
      .key_valid_o  (key_valid_o),
      .step_ready_i (step_ready_i),
      .dp_done_i    (dp_done_i),
      .result_i     (result_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0b expected %0b", name, act, want);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int want);
      tests++;
      if (act != want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, want);
      end
   endtask

   // Key pattern 1,0,1,0,... indexed from bit 0 of each run.
   function automatic logic pat(input int i);
      return (i % 2) == 0;
   endfunction

   // Key source: answers each next_key with the next pattern bit, restarting when idle.
   always @(negedge clk) begin
      if (!bus.enable) begin
         key_idx = 0;
         bus.ki  = 1'b0;
      end else if (bus.next_key) begin
         bus.ki = pat(key_idx);
         key_idx++;
      end
   end

   // Behavioural model: a run is KEY_BITS rounds of request/sample/present.
   logic [M-1:0] m_reg [4];
   logic [M-1:0] m_dout;
   logic [3:0]   m_mask, m_err, mask_now;
   int           m_mode, m_sub, m_bits;
   logic         m_kbit, m_trig;
   logic         m_live = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         foreach (m_reg[i]) m_reg[i] = '0;
         m_dout = '0; m_mask = 4'h0; m_err = 4'h0;
         m_mode = MIdle; m_sub = 0; m_bits = 0;
         m_kbit = 1'b0; m_trig = 1'b0; m_live = 1'b1;
      end else begin
         mask_now = m_mask;
         m_trig   = 1'b0;
         if ((m_mode == MFetch || m_mode == MDrain) && !bus.enable) begin
            m_mode = MIdle; m_bits = 0; m_err = 4'hE;
         end else begin
            case (m_mode)
               MIdle: begin
                  if (bus.load_data) begin
                     m_trig = 1'b1;
                     m_err  = 4'h0;
                     if (bus.load_status < 3'd4) begin
                        m_reg[bus.load_status[1:0]]  = bus.data_in;
                        m_mask[bus.load_status[1:0]] = 1'b1;
                     end else begin
                        m_err = 4'hF;
                     end
                  end
                  if (bus.enable && mask_now == 4'hF) begin
                     m_mode = MFetch; m_sub = 0; m_err = 4'h0;
                  end
               end
               MFetch: begin
                  if (m_sub == 0) m_sub = 1;
                  else if (m_sub == 1) begin m_kbit = bus.ki; m_sub = 2; end
                  else if (step_ready_i) begin
                     m_bits++;
                     m_sub = 0;
                     if (m_bits == int'(KEY_BITS)) m_mode = MDrain;
                  end
               end
               MDrain: if (dp_done_i) begin m_dout = result_i; m_mode = MFinish; end
               default: if (!bus.enable) begin m_mode = MIdle; m_mask = 4'h0; m_bits = 0; end
            endcase
         end
      end
   end

   function automatic int m_status();
      if (m_mode == MFetch)  return 3;
      if (m_mode == MDrain)  return 4;
      if (m_mode == MFinish) return 5;
      if (m_err != 4'h0)     return int'(m_err);
      if (m_mask == 4'h0)    return 0;
      return (m_mask == 4'hF) ? 2 : 1;
   endfunction

   always @(negedge clk) begin
      if (m_live) begin
         chk1("m_trigLoad", bus.trigLoad, m_trig);
         chk1("m_next_key", bus.next_key, m_mode == MFetch && m_sub == 0);
         chk1("m_key_valid", key_valid_o, m_mode == MFetch && m_sub == 2);
         chk1("m_key_bit", key_bit_o, m_kbit);
         chk1("m_done", bus.done, m_mode == MFinish);
         chk_int("m_becStatus", int'(bus.becStatus), m_status());
         chk("m_data_out", bus.data_out, m_dout);
         chk("m_xp", xp_o, m_reg[0]);
         chk("m_yp", yp_o, m_reg[1]);
         chk("m_w", w_o, m_reg[2]);
         chk("m_d", d_o, m_reg[3]);
      end
   end

   task automatic load_op(input logic [2:0] st, input logic [M-1:0] dat);
      @(negedge clk);
      bus.load_data = 1'b1; bus.load_status = st; bus.data_in = dat;
      @(negedge clk);
      bus.load_data = 1'b0;
   endtask

   // Caller raises enable at a negedge; follows the run until DRAIN.
   task automatic run_to_drain(input string tag);
      int cyc  = 0;
      int last = 0;
      nk = 0;
      while (bus.becStatus != 4'h4 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (bus.next_key) begin
            if (nk == 0) chk_int({tag, "_start_latency"}, cyc, 1);
            else         chk_int({tag, "_nk_spacing"}, cyc - last, 3);
            last = cyc;
            nk++;
         end
         if (key_valid_o) chk1({tag, "_key_bit"}, key_bit_o, pat(nk - 1));
      end
      chk_int({tag, "_nk_count"}, nk, int'(KEY_BITS));
      chk_int({tag, "_drain"}, int'(bus.becStatus), 4);
   endtask

   task automatic run_to_bit(input int b);
      int cyc = 0;
      while (!(key_valid_o && nk == b + 1) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (bus.next_key) nk++;
      end
      chk_int("reach_bit", nk, b + 1);
      chk1("reach_valid", key_valid_o, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      bus.enable = 1'b0; bus.load_data = 1'b0; bus.load_status = 3'd0; bus.data_in = '0;
      step_ready_i = 1'b0; dp_done_i = 1'b0; result_i = '0;
      repeat (2) @(negedge clk);
      chk_int("rst_status", int'(bus.becStatus), 0);
      chk1("rst_trig", bus.trigLoad, 1'b0);
      chk("rst_dout", bus.data_out, '0);
      chk("rst_xp", xp_o, '0);
      rst = 1'b0;

      // Back-to-back loads of all four operands.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk1("t1_trig", bus.trigLoad, 1'b1);
            chk_int("t1_status", int'(bus.becStatus), exp_st[i-1]);
         end
         bus.load_data = 1'b1; bus.load_status = 3'(i); bus.data_in = M'(i + 1);
      end
      @(negedge clk);
      chk1("t1_trig", bus.trigLoad, 1'b1);
      chk_int("t1_status", int'(bus.becStatus), exp_st[3]);
      bus.load_data = 1'b0;
      @(negedge clk);
      chk1("t1_trig_end", bus.trigLoad, 1'b0);
      chk("t1_xp", xp_o, M'(1));
      chk("t1_yp", yp_o, M'(2));
      chk("t1_w", w_o, M'(3));
      chk("t1_d", d_o, M'(4));

      // Invalid target.
      @(negedge clk);
      bus.load_data = 1'b1; bus.load_status = 3'd6; bus.data_in = '1;
      @(negedge clk);
      bus.load_data = 1'b0;
      chk1("t2_trig", bus.trigLoad, 1'b1);
      chk_int("t2_status", int'(bus.becStatus), 15);
      chk("t2_xp", xp_o, M'(1));
      chk("t2_d", d_o, M'(4));
      @(negedge clk);
      chk_int("t2_status_held", int'(bus.becStatus), 15);

      // Full run with step_ready tied high.
      step_ready_i = 1'b1;
      bus.enable   = 1'b1;
      run_to_drain("t3");
      @(negedge clk);
      dp_done_i = 1'b1; result_i = M'('h5A5);
      @(negedge clk);
      dp_done_i = 1'b0;
      chk1("t3_done", bus.done, 1'b1);
      chk("t3_dout", bus.data_out, M'('h5A5));
      chk_int("t3_status_fin", int'(bus.becStatus), 5);
      @(negedge clk);
      bus.enable = 1'b0;
      @(negedge clk);
      chk1("t3_done_clr", bus.done, 1'b0);
      chk_int("t3_status_idle", int'(bus.becStatus), 0);
      chk("t3_dout_kept", bus.data_out, M'('h5A5));

      // Backpressure on bit 10.
      load_op(3'd0, M'(10));
      load_op(3'd1, M'(11));
      load_op(3'd2, M'(12));
      load_op(3'd3, M'(13));
      @(negedge clk);
      bus.enable = 1'b1;
      nk = 0;
      run_to_bit(10);
      step_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk1("t4_valid", key_valid_o, 1'b1);
         chk1("t4_key_bit", key_bit_o, 1'b1);
         chk1("t4_no_nk", bus.next_key, 1'b0);
      end
      step_ready_i = 1'b1;

      // Abort at bit 50, then rerun without reload.
      run_to_bit(50);
      bus.enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_int("t5_status_abort", int'(bus.becStatus), 14);
         chk1("t5_valid_low", key_valid_o, 1'b0);
         chk1("t5_no_done", bus.done, 1'b0);
      end
      bus.enable = 1'b1;
      run_to_drain("t5");
      bus.enable = 1'b0;
      @(negedge clk);
      chk_int("t5_drain_abort", int'(bus.becStatus), 14);
      chk1("t5_drain_no_done", bus.done, 1'b0);

      // Load ignored while busy, then reset mid-run.
      bus.enable = 1'b1;
      nk = 0;
      run_to_bit(3);
      bus.load_data = 1'b1; bus.load_status = 3'd0; bus.data_in = '1;
      @(negedge clk);
      bus.load_data = 1'b0;
      chk1("t6_no_trig", bus.trigLoad, 1'b0);
      chk("t6_xp_kept", xp_o, M'(10));
      rst = 1'b1;
      @(negedge clk);
      chk1("t6_rst_trig", bus.trigLoad, 1'b0);
      chk1("t6_rst_nk", bus.next_key, 1'b0);
      chk1("t6_rst_valid", key_valid_o, 1'b0);
      chk1("t6_rst_done", bus.done, 1'b0);
      chk_int("t6_rst_status", int'(bus.becStatus), 0);
      chk("t6_rst_dout", bus.data_out, '0);
      chk("t6_rst_xp", xp_o, '0);
      chk("t6_rst_d", d_o, '0);
      rst = 1'b0;
      bus.enable = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
